// File: rtl/s_pea_out_stage.sv
// Output stage behind a streaming PE: buffers PE results in a small FIFO and derives pea_ready.
// Optional TLAST generation is enabled by defining S_PEA_OUT_STAGE_TLAST_EN.
module s_pea_out_stage #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_BITS-1:0]          pe_res_i,
  input  logic                       pe_valid_i,
  output logic                       pea_ready_o,
  input  logic                       flush_i,
  output logic [N_BITS-1:0]          out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
`ifdef S_PEA_OUT_STAGE_TLAST_EN
  input  logic [15:0]                len_i,
  output logic                       out_last_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW:0]   READY_LIM = (CW + 1)'(DEPTH - 1);

  logic [N_BITS-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ready_d1_r;
  logic              overflow_r;

  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              wr_en_s;
  logic              ready_s;
  logic [CW:0]       occ_s;

  // Handshake decode; ready counts the beat that may still land one cycle after ready was high.
  always_comb begin
    push_s  = pe_valid_i && ready_d1_r;
    pop_s   = (count_r != {CW{1'b0}}) && out_ready_i;
    full_s  = (count_r == FULL_CNT);
    wr_en_s = push_s && (!full_s || pop_s);
    occ_s   = {1'b0, count_r} + {{CW{1'b0}}, ready_d1_r};
    ready_s = (occ_s <= READY_LIM);
  end

  // Pointer, occupancy, ready history and sticky overflow state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      ready_d1_r <= 1'b0;
      overflow_r <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      ready_d1_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      ready_d1_r <= ready_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care after reset or flush.
  always_ff @(posedge clk_i) begin
    if (wr_en_s && !flush_i) begin
      mem_r[wr_ptr_r] <= pe_res_i;
    end
  end

  assign pea_ready_o = ready_s;
  assign out_valid_o = (count_r != {CW{1'b0}});
  assign out_data_o  = out_valid_o ? mem_r[rd_ptr_r] : {N_BITS{1'b0}};
  assign count_o     = count_r;
  assign overflow_o  = overflow_r;

`ifdef S_PEA_OUT_STAGE_TLAST_EN
  logic [15:0] beat_cnt_r;
  logic        last_s;

  // len_i of zero never marks a last beat; the counter then wraps on its own.
  always_comb begin
    last_s = out_valid_o && (len_i != 16'd0) && (beat_cnt_r == (len_i - 16'd1));
  end

  // Beats popped within the current transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_r <= 16'd0;
    end else if (flush_i) begin
      beat_cnt_r <= 16'd0;
    end else if (pop_s) begin
      beat_cnt_r <= last_s ? 16'd0 : (beat_cnt_r + 16'd1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign out_last_o = last_s;
`endif

endmodule

// File: tb/tb_s_pea_out_stage.sv
// Directed self-checking bench for s_pea_out_stage (DEPTH=4, N_BITS=32).
module tb_s_pea_out_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pe_res;
  logic        pe_valid;
  logic        pea_ready;
  logic        flush;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;
`ifdef S_PEA_OUT_STAGE_TLAST_EN
  logic [15:0] len;
  logic        out_last;
`endif

  int n_checks;
  int n_fail;

  s_pea_out_stage #(.N_BITS(32), .DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pe_res_i    (pe_res),
    .pe_valid_i  (pe_valid),
    .pea_ready_o (pea_ready),
    .flush_i     (flush),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef S_PEA_OUT_STAGE_TLAST_EN
    .len_i       (len),
    .out_last_o  (out_last),
`endif
    .count_o     (count),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; pe_valid = 1'b0; pe_res = 32'd0; out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // PE model: loads a new beat after an edge at which pea_ready was high, otherwise holds.
  task automatic fill(input int n_edges, input logic [31:0] base);
    int   idx;
    logic en;
    idx = 0;
    out_ready = 1'b0;
    for (int e = 0; e < n_edges; e++) begin
      en = pea_ready;
      tick();
      if (en && idx < 4) begin
        pe_valid = 1'b1;
        pe_res   = base + 32'(idx);
        idx++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pe_valid = 1'b0; pe_res = 32'd0; out_ready = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    n_checks++; if (pea_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", pea_ready); end
  endtask

  task automatic test_stream();
    logic [7:0] last_mask;
    last_mask = 8'b0010_0100;
`ifdef S_PEA_OUT_STAGE_TLAST_EN
    len = 16'd3;
`endif
    apply_reset();
    out_ready = 1'b1;
    tick();
    pe_valid = 1'b1;
    pe_res   = 32'h11;
    for (int n = 0; n < 8; n++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b expected 1", n, out_valid); end
      n_checks++; if (out_data !== 32'h11 + 32'(n)) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", n, out_data, 32'h11 + 32'(n)); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", n, count); end
      n_checks++; if (pea_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %0b expected 1", n, pea_ready); end
`ifdef S_PEA_OUT_STAGE_TLAST_EN
      n_checks++; if (out_last !== last_mask[n]) begin n_fail++; $display("FAIL stream_last[%0d]: got %0b expected %0b", n, out_last, last_mask[n]); end
`endif
      pe_res = 32'h12 + 32'(n);
      if (n == 7) pe_valid = 1'b0;
    end
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_end_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid: got %0b expected 0", out_valid); end
`ifdef S_PEA_OUT_STAGE_TLAST_EN
    len = 16'd0;
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] beats [4];
    logic [2:0]  exp_cnt [8];
    logic        exp_rdy [8];
    logic [31:0] drain_data [4];
    int          idx;
    logic        en;
    beats      = '{32'h21, 32'h22, 32'h23, 32'hAA};
    exp_cnt    = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    exp_rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drain_data = '{32'h22, 32'h23, 32'hAA, 32'h0};
    apply_reset();
    idx = 0;
    for (int e = 0; e < 8; e++) begin
      en = pea_ready;
      tick();
      if (en && idx < 4) begin
        pe_valid = 1'b1;
        pe_res   = beats[idx];
        idx++;
      end
      n_checks++; if (count !== exp_cnt[e]) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected %0d", e, count, exp_cnt[e]); end
      n_checks++; if (pea_ready !== exp_rdy[e]) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b expected %0b", e, pea_ready, exp_rdy[e]); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow[%0d]: got %0b expected 0", e, overflow); end
    end
    n_checks++; if (out_data !== 32'h21) begin n_fail++; $display("FAIL bp_head: got %0h expected 21", out_data); end
    pe_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      tick();
      n_checks++; if (out_data !== drain_data[d]) begin n_fail++; $display("FAIL bp_drain_data[%0d]: got %0h expected %0h", d, out_data, drain_data[d]); end
      n_checks++; if (count !== 3'(3 - d)) begin n_fail++; $display("FAIL bp_drain_count[%0d]: got %0d expected %0d", d, count, 3 - d); end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_full_overflow();
    logic [31:0] drain_data [4];
    drain_data = '{32'h43, 32'h44, 32'h5A, 32'h0};
    apply_reset();
    fill(5, 32'h41);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
    force dut.ready_d1_r = 1'b1;
    pe_valid  = 1'b1;
    pe_res    = 32'h5A;
    out_ready = 1'b1;
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pushpop_count: got %0d expected 4", count); end
    n_checks++; if (out_data !== 32'h42) begin n_fail++; $display("FAIL full_pushpop_head: got %0h expected 42", out_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_overflow: got %0b expected 0", overflow); end
    out_ready = 1'b0;
    pe_res    = 32'h5B;
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", count); end
    release dut.ready_d1_r;
    pe_valid = 1'b0;
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      tick();
      n_checks++; if (out_data !== drain_data[d]) begin n_fail++; $display("FAIL full_drain_data[%0d]: got %0h expected %0h", d, out_data, drain_data[d]); end
      n_checks++; if (count !== 3'(3 - d)) begin n_fail++; $display("FAIL full_drain_count[%0d]: got %0d expected %0d", d, count, 3 - d); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_after_drain: got %0b expected 1", overflow); end
  endtask

  task automatic test_flush();
    fill(4, 32'h61);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    pe_valid = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL flush_data: got %0h expected 0", out_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_overflow: got %0b expected 0", overflow); end
    n_checks++; if (pea_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b expected 1", pea_ready); end
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_discard: got %0d expected 0", count); end
  endtask

  task automatic test_async_reset();
    fill(4, 32'h71);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL areset_pre_count: got %0d expected 3", count); end
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b expected 0", out_valid); end
    n_checks++; if (pea_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %0b expected 1", pea_ready); end
    pe_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef S_PEA_OUT_STAGE_TLAST_EN
    len = 16'd0;
`endif
    test_reset();
    test_stream();
    test_backpressure();
    test_full_overflow();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
